// File: rtl/csr_hpm_counters_pkg.sv
// rtl/csr_hpm_counters_pkg.sv - shared CSR addresses, field positions and slot masks for the HPM block
//
// Purpose: address constants for the counter/event CSRs, mhpmevent field
// positions, counter slot indices and helpers that build slot masks.
package csr_hpm_counters_pkg;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;

    localparam int MHPMEVENT_OF     = 31;
    localparam int MHPMEVENT_SEL_HI = 4;
    localparam int MHPMEVENT_SEL_LO = 0;

    localparam int IDX_MCYCLE    = 0;
    localparam int IDX_MINSTRET  = 2;
    localparam int IDX_HPM_FIRST = 3;

    localparam logic [1:0] PRIV_M = 2'd3;

    // Counter CSRs come in 32-entry blocks; bits [11:5] name the block.
    function automatic logic [6:0] csr_block(input logic [11:0] addr);
        return addr[11:5];
    endfunction

    // Slots that hold a programmable counter.
    function automatic logic [31:0] hpm_mask(input int num_hpm);
        logic [31:0] m;
        m = '0;
        for (int i = IDX_HPM_FIRST; i < 32; i++) begin
            if (i < IDX_HPM_FIRST + num_hpm) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Slots that hold any counter (mcycle, minstret, programmable).
    function automatic logic [31:0] cnt_mask(input int num_hpm);
        logic [31:0] m;
        m = hpm_mask(num_hpm);
        m[IDX_MCYCLE]   = 1'b1;
        m[IDX_MINSTRET] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/csr_hpm_counters_if.sv
// rtl/csr_hpm_counters_if.sv - CSR read/write port bundle for the HPM block
//
// Purpose: groups the issue-stage read port, writeback write port and the
// privilege inputs used for user alias checks.
// master: drives csr_ren/csr_raddr/csr_waddr/csr_wdata/priv/counteren,
//         receives csr_rdata/csr_hit/csr_fault.
// slave : the counter block.
interface csr_hpm_counters_if;
    logic        csr_ren;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic [1:0]  priv;
    logic [31:0] counteren;
    logic        csr_fault;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;

    modport master (
        output csr_ren, csr_raddr, priv, counteren, csr_waddr, csr_wdata,
        input  csr_rdata, csr_hit, csr_fault
    );

    modport slave (
        input  csr_ren, csr_raddr, priv, counteren, csr_waddr, csr_wdata,
        output csr_rdata, csr_hit, csr_fault
    );
endinterface

// File: rtl/csr_hpm_slice.sv
// rtl/csr_hpm_slice.sv - one performance counter with split 32-bit write halves
//
// Purpose: a single COUNTER_W-bit counter.
// Ports: clk_i, rst_i (async, active-high); inc_i increment amount;
//        inhibit_i freezes counting; wr_lo_i/wr_hi_i replace the low word or
//        the bits above 31 with wdata_i; value_o current count; wrap_o high
//        when this cycle's increment carries out of the top bit.
module csr_hpm_slice #(
    parameter int COUNTER_W = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [COUNTER_W-1:0] inc_i,
    input  logic                 inhibit_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [31:0]          wdata_i,
    output logic [COUNTER_W-1:0] value_o,
    output logic                 wrap_o
);

    logic [COUNTER_W-1:0] value_q, value_d;
    logic [COUNTER_W:0]   sum;

    always_comb begin
        sum = {1'b0, value_q} + {1'b0, inc_i};
        // Wrap is reported even when a write replaces the count this cycle,
        // so the overflow flag still gets set.
        wrap_o  = !inhibit_i && sum[COUNTER_W];
        value_d = value_q;
        if (wr_lo_i || wr_hi_i) begin
            // The unwritten half keeps its pre-cycle value, not the incremented one.
            if (wr_lo_i) value_d[31:0] = wdata_i;
            if (wr_hi_i) value_d[COUNTER_W-1:32] = wdata_i[COUNTER_W-33:0];
        end else if (!inhibit_i) begin
            value_d = sum[COUNTER_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value_o = value_q;

endmodule

// File: rtl/csr_hpm_counters.sv
// rtl/csr_hpm_counters.sv - mcycle/minstret/mhpmcounter block with inhibit, event select and overflow IRQ
//
// Purpose: counter CSRs beside the register file; read combinationally at
// issue, written from writeback.
// Ports: clk_i, rst_i (async, active-high); event_i per-cycle event pulses;
//        instret_i retirements this cycle; bus (slave) CSR read/write port,
//        hit/fault flags; ovf_irq_o registered OR of all overflow flags.
module csr_hpm_counters
    import csr_hpm_counters_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int COUNTER_W  = 64,
    parameter int NUM_EVENTS = 8,
    parameter int RETIRE_W   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [RETIRE_W-1:0]   instret_i,
    csr_hpm_counters_if.slave     bus,
    output logic                  ovf_irq_o
);

    localparam logic [31:0] HPM_MASK = hpm_mask(NUM_HPM);
    localparam logic [31:0] CNT_MASK = cnt_mask(NUM_HPM);

    localparam logic [6:0] BLK_M_LO = csr_block(CSR_MCYCLE);
    localparam logic [6:0] BLK_M_HI = csr_block(CSR_MCYCLEH);
    localparam logic [6:0] BLK_U_LO = csr_block(CSR_CYCLE);
    localparam logic [6:0] BLK_U_HI = csr_block(CSR_CYCLEH);
    localparam logic [6:0] BLK_EVT  = csr_block(CSR_MHPMEVENT3);

    logic [31:0]          inhibit_q;
    logic [4:0]           sel_q [32];
    logic [31:0]          of_q;
    logic                 irq_q;

    logic [COUNTER_W-1:0] value [32];
    logic [31:0]          wrap;
    logic [31:0]          of_set;
    logic [31:0]          ev_vec;

    logic [31:0]          wr_lo, wr_hi, wr_evt, w_onehot;
    logic                 wr_inh;

    // Event mux input: bit 0 is "no event", bits above NUM_EVENTS stay 0 so
    // out-of-range selectors count nothing.
    always_comb begin
        ev_vec = '0;
        ev_vec[NUM_EVENTS:1] = event_i;
    end

    // Write decode; only the machine block is writable, aliases are ignored.
    always_comb begin
        w_onehot = 32'h1 << bus.csr_waddr[4:0];
        wr_lo    = (csr_block(bus.csr_waddr) == BLK_M_LO) ? (w_onehot & CNT_MASK) : '0;
        wr_hi    = (csr_block(bus.csr_waddr) == BLK_M_HI) ? (w_onehot & CNT_MASK) : '0;
        wr_evt   = (csr_block(bus.csr_waddr) == BLK_EVT)  ? (w_onehot & HPM_MASK) : '0;
        wr_inh   = (bus.csr_waddr == CSR_MCOUNTINHIBIT);
    end

    for (genvar i = 0; i < 32; i++) begin : g_slot
        if (CNT_MASK[i]) begin : g_cnt
            logic [COUNTER_W-1:0] inc;
            if (i == IDX_MCYCLE) begin : g_cyc
                assign inc = COUNTER_W'(1);
            end else if (i == IDX_MINSTRET) begin : g_ret
                assign inc = COUNTER_W'(instret_i);
            end else begin : g_evt
                assign inc = COUNTER_W'(ev_vec[sel_q[i]]);
            end
            csr_hpm_slice #(.COUNTER_W(COUNTER_W)) u_slice (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .inc_i     (inc),
                .inhibit_i (inhibit_q[i]),
                .wr_lo_i   (wr_lo[i]),
                .wr_hi_i   (wr_hi[i]),
                .wdata_i   (bus.csr_wdata),
                .value_o   (value[i]),
                .wrap_o    (wrap[i])
            );
        end else begin : g_none
            assign value[i] = '0;
            assign wrap[i]  = 1'b0;
        end
    end

    // mcycle/minstret carry no overflow flag.
    assign of_set = wrap & HPM_MASK;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inhibit_q <= '0;
            of_q      <= '0;
            irq_q     <= 1'b0;
            for (int k = 0; k < 32; k++) sel_q[k] <= '0;
        end else begin
            if (wr_inh) inhibit_q <= bus.csr_wdata & CNT_MASK;
            irq_q <= |of_q;
            for (int k = 0; k < 32; k++) begin
                if (HPM_MASK[k]) begin
                    // A wrap in the same cycle as an mhpmevent write still leaves OF set.
                    if (wr_evt[k]) begin
                        sel_q[k] <= bus.csr_wdata[MHPMEVENT_SEL_HI:MHPMEVENT_SEL_LO];
                        of_q[k]  <= bus.csr_wdata[MHPMEVENT_OF] | of_set[k];
                    end else if (of_set[k]) begin
                        of_q[k]  <= 1'b1;
                    end
                end
            end
        end
    end

    assign ovf_irq_o = irq_q;

    // Read decode and data mux, all combinational on pre-edge state.
    logic [6:0]  r_blk;
    logic [4:0]  r_idx;
    logic        r_lo, r_hi, r_alias, r_cnt, r_inh, r_evt;
    logic [63:0] r_val;

    always_comb begin
        r_blk   = csr_block(bus.csr_raddr);
        r_idx   = bus.csr_raddr[4:0];
        r_lo    = (r_blk == BLK_M_LO) || (r_blk == BLK_U_LO);
        r_hi    = (r_blk == BLK_M_HI) || (r_blk == BLK_U_HI);
        r_alias = (r_blk == BLK_U_LO) || (r_blk == BLK_U_HI);
        // Slot 1 is the time CSR, which lives elsewhere.
        r_cnt   = (r_lo || r_hi) && (r_idx != 5'd1);
        r_inh   = (bus.csr_raddr == CSR_MCOUNTINHIBIT);
        r_evt   = (r_blk == BLK_EVT) && (r_idx >= 5'(IDX_HPM_FIRST));
        r_val   = 64'(value[r_idx]);

        bus.csr_hit   = r_cnt || r_inh || r_evt;
        bus.csr_fault = bus.csr_ren && r_cnt && r_alias &&
                        (bus.priv != PRIV_M) && !bus.counteren[r_idx];

        bus.csr_rdata = '0;
        if (bus.csr_ren) begin
            if (r_cnt) begin
                bus.csr_rdata = r_lo ? r_val[31:0] : r_val[63:32];
            end else if (r_inh) begin
                bus.csr_rdata = inhibit_q;
            end else if (r_evt) begin
                bus.csr_rdata[MHPMEVENT_OF] = of_q[r_idx];
                bus.csr_rdata[MHPMEVENT_SEL_HI:MHPMEVENT_SEL_LO] = sel_q[r_idx];
            end
        end
    end

endmodule

// File: tb/tb_csr_hpm_counters.sv
// tb/tb_csr_hpm_counters.sv - scoreboard bench for csr_hpm_counters against a behavioural model
module tb_csr_hpm_counters;

    localparam int NUM_HPM    = 4;
    localparam int COUNTER_W  = 64;
    localparam int NUM_EVENTS = 8;
    localparam int RETIRE_W   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_EVENTS-1:0] event_i;
    logic [RETIRE_W-1:0]   instret_i;
    logic                  ovf_irq;

    csr_hpm_counters_if bus ();

    csr_hpm_counters #(
        .NUM_HPM    (NUM_HPM),
        .COUNTER_W  (COUNTER_W),
        .NUM_EVENTS (NUM_EVENTS),
        .RETIRE_W   (RETIRE_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .event_i   (event_i),
        .instret_i (instret_i),
        .bus       (bus),
        .ovf_irq_o (ovf_irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: counters indexed by CSR slot number.
    longint unsigned m_cnt [32];
    bit [31:0]       m_inh;
    bit [4:0]        m_sel [32];
    bit              m_of  [32];
    bit              m_irq;
    logic [1:0]      cur_priv = 2'd3;
    logic [31:0]     cur_cen  = 32'hFFFF_FFFF;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        bit          hit;
        bit          flt;
        bit          irq;
    } exp_t;
    exp_t scb[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] rd_tab [30] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                                 12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'hB07, 12'hB87, 12'hB01, 12'hB81,
                                 12'hC00, 12'hC02, 12'hC03, 12'hC06, 12'hC80, 12'hC83, 12'hC01, 12'h320,
                                 12'h321, 12'h323, 12'h324, 12'h325, 12'h326, 12'h327};
    logic [11:0] wr_tab [20] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                                 12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'hB07, 12'hB10, 12'hC03, 12'h320,
                                 12'h323, 12'h324, 12'h325, 12'h326};

    function automatic bit has_counter(int i);
        return (i == 0) || (i == 2) || (i >= 3 && i < 3 + NUM_HPM);
    endfunction

    function automatic bit is_hpm(int i);
        return (i >= 3) && (i < 3 + NUM_HPM);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_cnt[i] = 0;
            m_sel[i] = 0;
            m_of[i]  = 0;
        end
        m_inh = 0;
        m_irq = 0;
    endtask

    task automatic model_read(input logic [11:0] a, output bit hit, output logic [31:0] d, output bit flt);
        int i;
        hit = 0; d = 0; flt = 0;
        i = int'(a) % 32;
        if ((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hC00 && a <= 12'hC1F)) begin
            if (i != 1) begin hit = 1; d = m_cnt[i][31:0]; end
        end else if ((a >= 12'hB80 && a <= 12'hB9F) || (a >= 12'hC80 && a <= 12'hC9F)) begin
            if (i != 1) begin hit = 1; d = 32'(m_cnt[i] >> 32); end
        end else if (a == 12'h320) begin
            hit = 1; d = m_inh;
        end else if (a >= 12'h323 && a <= 12'h33F) begin
            i = int'(a) - 'h320;
            hit = 1; d = {m_of[i], 26'h0, m_sel[i]};
        end
        if (hit && a >= 12'hC00 && cur_priv != 2'd3 && !cur_cen[i]) flt = 1;
    endtask

    task automatic model_edge(input logic [7:0] ev, input logic [1:0] ret, input logic [11:0] wa, input logic [31:0] wd);
        longint unsigned nxt [32];
        bit              wrapped [32];
        longint unsigned amt;
        bit              any_of;
        bit [31:0]       writable;
        int              i;
        any_of = 0;
        writable = 0;
        for (int k = 0; k < 32; k++) begin
            any_of |= m_of[k];
            if (has_counter(k)) writable[k] = 1;
            nxt[k] = m_cnt[k];
            wrapped[k] = 0;
            if (has_counter(k) && !m_inh[k]) begin
                amt = 0;
                if (k == 0) amt = 1;
                else if (k == 2) amt = longint'(ret);
                else if (m_sel[k] >= 1 && m_sel[k] <= NUM_EVENTS) amt = longint'(ev[m_sel[k] - 1]);
                if (is_hpm(k) && amt != 0 && m_cnt[k] == 64'hFFFF_FFFF_FFFF_FFFF) wrapped[k] = 1;
                nxt[k] = m_cnt[k] + amt;
            end
        end
        i = int'(wa) % 32;
        if (wa >= 12'hB00 && wa <= 12'hB1F && has_counter(i))
            nxt[i] = (m_cnt[i] & 64'hFFFF_FFFF_0000_0000) | longint'(wd);
        if (wa >= 12'hB80 && wa <= 12'hB9F && has_counter(i))
            nxt[i] = (m_cnt[i] & 64'h0000_0000_FFFF_FFFF) | (longint'(wd) << 32);
        for (int k = 0; k < 32; k++) begin
            if (is_hpm(k)) begin
                if (int'(wa) == 'h320 + k) begin
                    m_sel[k] = wd[4:0];
                    m_of[k]  = wd[31] | wrapped[k];
                end else if (wrapped[k]) begin
                    m_of[k] = 1;
                end
            end
            m_cnt[k] = nxt[k];
        end
        if (wa == 12'h320) m_inh = wd & writable;
        m_irq = any_of;
    endtask

    task automatic chk(input string nm, input logic [11:0] a, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s addr=%h actual=%h required=%h at %0t", nm, a, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per cycle, compared away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (scb.size() != 0) begin
                e = scb.pop_front();
                chk("irq",   e.addr, 32'(ovf_irq),       32'(e.irq));
                chk("hit",   e.addr, 32'(bus.csr_hit),   32'(e.hit));
                chk("rdata", e.addr, bus.csr_rdata,      e.data);
                chk("fault", e.addr, 32'(bus.csr_fault), 32'(e.flt));
            end
        end
    end

    // One clock cycle of stimulus; kuse replaces the model's read data with a fixed value.
    task automatic step(input logic [7:0] ev, input logic [1:0] ret, input bit ren, input logic [11:0] ra,
                        input logic [11:0] wa, input logic [31:0] wd, input bit kuse = 0, input logic [31:0] kval = 0);
        exp_t        e;
        bit          h, f;
        logic [31:0] d;
        event_i = ev; instret_i = ret;
        bus.csr_ren = ren; bus.csr_raddr = ra; bus.csr_waddr = wa; bus.csr_wdata = wd;
        bus.priv = cur_priv; bus.counteren = cur_cen;
        model_read(ra, h, d, f);
        if (!ren) begin d = 0; f = 0; end
        else if (kuse) d = kval;
        e.addr = ra; e.data = d; e.hit = h; e.flt = f; e.irq = m_irq;
        scb.push_back(e);
        @(posedge clk);
        if (!rst) model_edge(ev, ret, wa, wd);
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        step(8'h0, 2'd0, 1'b1, a, 12'h0, 32'h0);
    endtask

    task automatic rdk(input logic [11:0] a, input logic [31:0] k);
        step(8'h0, 2'd0, 1'b1, a, 12'h0, 32'h0, 1'b1, k);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        step(8'h0, 2'd0, 1'b0, 12'h0, a, d);
    endtask

    task automatic pulse(input logic [7:0] ev);
        step(ev, 2'd0, 1'b0, 12'h0, 12'h0, 32'h0);
    endtask

    initial begin
        logic [11:0] wa, ra;
        logic [31:0] wd;
        rst = 1'b1;
        event_i = '0; instret_i = '0;
        bus.csr_ren = 1'b0; bus.csr_raddr = '0; bus.csr_waddr = '0; bus.csr_wdata = '0;
        bus.priv = cur_priv; bus.counteren = cur_cen;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset and count
        repeat (10) pulse(8'h0);
        rdk(12'hB00, 32'd10);
        rdk(12'hB02, 32'd0);
        for (int k = 0; k < 4; k++) rdk(12'h323 + 12'(k), 32'h0);

        // High-half write and carry
        wr(12'hB80, 32'h1);
        wr(12'hB00, 32'hFFFF_FFFF);
        rdk(12'hB00, 32'hFFFF_FFFF);
        rdk(12'hB80, 32'h2);
        rd(12'hB00);

        // Event select and inhibit
        wr(12'h323, 32'h2);
        repeat (5) pulse(8'h02);
        rdk(12'hB03, 32'd5);
        wr(12'h320, 32'h8);
        repeat (3) pulse(8'h02);
        rdk(12'hB03, 32'd5);
        rdk(12'h320, 32'h8);

        // Overflow and IRQ
        wr(12'h320, 32'h0);
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        pulse(8'h02);
        rdk(12'hB03, 32'h0);
        rdk(12'h323, 32'h8000_0002);
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        step(8'h02, 2'd0, 1'b0, 12'h0, 12'h323, 32'h0);
        rdk(12'h323, 32'h8000_0000);
        wr(12'h323, 32'h0);
        repeat (3) rd(12'h323);

        // Counter write in the same cycle as a wrap
        wr(12'h323, 32'h2);
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        step(8'h02, 2'd0, 1'b0, 12'h0, 12'hB03, 32'h1234);
        rdk(12'hB03, 32'h1234);
        rdk(12'h323, 32'h8000_0002);
        wr(12'h323, 32'h0);

        // User access
        cur_priv = 2'd0; cur_cen = 32'h1;
        rd(12'hC00);
        rd(12'hC02);
        wr(12'hC00, 32'h5);
        rd(12'hC00);
        rd(12'hC01);
        cur_priv = 2'd3; cur_cen = 32'hFFFF_FFFF;

        // Unimplemented counter and time slot
        rdk(12'hB10, 32'h0);
        wr(12'hB10, 32'hABCD);
        rdk(12'hB10, 32'h0);
        rd(12'hB01);
        rd(12'h321);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ra = rd_tab[$urandom_range(0, 29)];
            wa = 12'h0;
            wd = $urandom;
            if ($urandom_range(0, 9) < 3) begin
                wa = wr_tab[$urandom_range(0, 19)];
                if (wa == 12'h320) wd = $urandom & $urandom & 32'h7F;
                else if (wa >= 12'h323 && wa <= 12'h326) wd = {1'($urandom), 26'($urandom), 5'($urandom_range(0, 9))};
                else if ($urandom_range(0, 1) == 1) wd = 32'hFFFF_FFFF;
            end
            case ($urandom_range(0, 2))
                0: cur_priv = 2'd0;
                1: cur_priv = 2'd1;
                default: cur_priv = 2'd3;
            endcase
            cur_cen = $urandom;
            step(8'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0), ra, wa, wd);
        end

        // Reset mid-operation
        cur_priv = 2'd3; cur_cen = 32'hFFFF_FFFF;
        rst = 1'b1;
        model_reset();
        rdk(12'hB00, 32'h0);
        rdk(12'h320, 32'h0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        model_edge(8'h0, 2'd0, 12'h0, 32'h0);
        repeat (3) pulse(8'h0);
        rdk(12'hB00, 32'd4);
        rdk(12'h323, 32'h0);

        n_checks++;
        if (scb.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending=%0d required=0", scb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/csr_hpm_counters.md
# csr_hpm_counters

Parametrised hardware performance-monitor block for the RV32 core. It implements `mcycle`, `minstret`, `NUM_HPM` programmable `mhpmcounterN` counters with event selectors, `mcountinhibit`, the user-mode shadow aliases, and sticky overflow flags that drive a local counter-overflow interrupt. It sits beside the CSR register file. It is read at issue with the same address/data style as the register file, and written from writeback.

## Interface
- `NUM_HPM`, default 4: programmable counters implemented (0..29), starting at index 3.
- `COUNTER_W`, default 64: counter width (33..64); bits above `COUNTER_W` read as 0.
- `NUM_EVENTS`, default 8: width of `event_i` (1..31).
- `RETIRE_W`, default 1: width of `instret_i` (retirements per cycle, unsigned).
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `event_i`, in, `NUM_EVENTS`: per-cycle event pulses; a high bit counts +1 that cycle.
- `instret_i`, in, `RETIRE_W`: instructions retired this cycle.
- `csr_ren_i`, in, 1: read strobe at issue.
- `csr_raddr_i`, in, 12: read address.
- `csr_rdata_o`, out, 32: read data, combinational; 0 when `csr_ren_i`=0 or on a miss.
- `csr_hit_o`, out, 1: `csr_raddr_i` decodes to this block. Combinational.
- `priv_i`, in, 2: current privilege.
- `counteren_i`, in, 32: effective counter-enable mask for `priv_i`. Machine mode passes all ones.
- `csr_fault_o`, out, 1: access to a 0xCxx alias with the `counteren_i` bit clear while `priv_i`≠M. Combinational.
- `csr_waddr_i`, in, 12: write address; 0 means no write.
- `csr_wdata_i`, in, 32: write data.
- `ovf_irq_o`, out, 1: OR of all overflow flags, registered.

## Operation
- **Address map.**
  - 0xB00/0xB80: `mcycle` low/high.
  - 0xB02/0xB82: `minstret` low/high.
  - 0xB03+k/0xB83+k: `mhpmcounter(3+k)` low/high, k=0..28.
  - 0x320: `mcountinhibit`; bits 0, 2 and 3..3+`NUM_HPM`-1 are writable, all other bits read 0.
  - 0x323+k: `mhpmevent(3+k)`.
  - 0xC00–0xC1F and 0xC80–0xC9F: read-only aliases of 0xB00–0xB1F and 0xB80–0xB9F. Writes to them are ignored.
  - 0xB01, 0xB81, 0xC01 and 0xC81 (the `time` slots) are misses.
- **Unimplemented counters.** Indices k ≥ `NUM_HPM` in the ranges above hit, read 0, and ignore writes.
- **`mhpmevent` layout.**
  - Bit 31 is OF, the sticky overflow flag.
  - Bits [4:0] are SEL: 0 means no event; v in 1..`NUM_EVENTS` counts `event_i[v-1]`; any other value counts nothing.
  - All other bits read 0.
- **Increment per cycle.** An uninhibited counter adds:
  - `mcycle`: +1.
  - `minstret`: `instret_i`, zero-extended.
  - HPM counter: +1 when its selected event bit is high.
  - Arithmetic is modulo 2^`COUNTER_W`.
- **Overflow.** An HPM increment that wraps the counter from all ones to 0 sets its OF. `mcycle` and `minstret` have no OF.
- **Writes.**
  - A low-half write replaces bits [31:0]; a high-half write replaces bits [`COUNTER_W`-1:32].
  - The other half keeps its pre-cycle value.
  - A write suppresses that counter's increment in that cycle; the written value appears exactly.
- **Fault.** `csr_fault_o`=1 for a read of 0xC00+i or 0xC80+i when `priv_i`≠3 and `counteren_i[i]`=0. Read data is still driven, and the caller discards it.

## Timing
- **Reset.** All counters, `mcountinhibit`, every `mhpmevent` and `ovf_irq_o` are 0. Counting starts on the first clock edge after reset is released.
- **Reset mid-operation.** Asserting `rst_i` clears all state immediately (asynchronous). No partial write survives.
- **Read latency.** Reads are combinational and return pre-edge state. A read and a write to the same CSR in the same cycle return the old value.
- **Write visibility.** A write is visible to reads from the next cycle onward.
- **Inhibit.** A write to `mcountinhibit` takes effect from the next cycle. The write cycle itself uses the old inhibit value.
- **Overflow interrupt.** OF is set at the edge where the wrap occurs. `ovf_irq_o` rises one cycle later, and falls one cycle after the last OF clears.
- **Simultaneous events.**
  - A wrap in the same cycle as an `mhpmevent` write: OF ends at 1; SEL takes the written value.
  - A counter write in the same cycle as a wrap: the write wins, and OF is still set.
- **Mid-count writes.** Writing SEL or inhibit mid-count causes no spurious increment.

## Structure
- The CSR address constants (`CSR_MCYCLE`, `CSR_MCOUNTINHIBIT`, `CSR_MHPMEVENT3`, etc.) and the `MHPMEVENT_OF` / `SEL` field ranges go in the shared `DEFINITIONS.v`.
- Sub-module `csr_hpm_slice` holds one counter:
  - Parameter: `COUNTER_W`.
  - Inputs: inc, inhibit, wr_lo, wr_hi, wdata.
  - Outputs: value, wrap.
- The top level instantiates `2+NUM_HPM` slices and adds address decode, the event mux, OF flags and the IRQ register.

## Test plan
- **Reset and count.** Release reset, idle 10 cycles → `mcycle` reads 10; `minstret` = 0; all `mhpmevent` read 0.
- **High-half write and carry.** Write 0xB80=0x1, then 0xB00=0xFFFFFFFF → next cycle reads low 0xFFFFFFFF / high 0x1; one cycle later low 0x0 / high 0x2.
- **Event select and inhibit.**
  - Setup: `mhpmevent3` SEL=2, pulse `event_i[1]` 5 times → `mhpmcounter3` = 5.
  - Then set `mcountinhibit` bit 3 and pulse 3 more → still 5.
- **Overflow and IRQ.**
  - Setup: preload `mhpmcounter3` with 2^`COUNTER_W`-1, one event pulse → counter = 0, OF = 1, `ovf_irq_o` high the following cycle.
  - Same-cycle clear attempt: write `mhpmevent3`=0 in the same cycle as a second wrap → OF remains 1.
- **User access.** `priv_i`=0, `counteren_i`=0x1: read 0xC00 → fault 0; read 0xC02 → fault 1; write 0xC00 → no change.
- **Unimplemented counter.** `NUM_HPM`=4: 0xB10 hits, reads 0, ignores writes; 0xB01 is a miss (`csr_hit_o`=0).
